// File: rtl/mem_stage_pkg.sv
// Shared encodings and helpers for the memory-access stage.
// Optional forwarding is enabled by defining MEM_FWD_EN.
package mem_stage_pkg;

  localparam int DATA_W    = 32;
  localparam int REG_IDX_W = 5;

  localparam logic [1:0] MEMOP_NONE  = 2'd0;
  localparam logic [1:0] MEMOP_LOAD  = 2'd1;
  localparam logic [1:0] MEMOP_STORE = 2'd2;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam logic [DATA_W-1:0] ZERO32 = '0;

  // Index of the final byte of an access; sizes 10 and 11 are both words.
  function automatic logic [1:0] last_byte(input logic [1:0] size);
    case (size)
      SIZE_BYTE: last_byte = 2'd0;
      SIZE_HALF: last_byte = 2'd1;
      default:   last_byte = 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Assembles a little-endian load buffer into a register value,
// zero- or sign-extending according to size and the unsigned bit.
module mem_load_ext
  import mem_stage_pkg::*;
(
  input  logic [DATA_W-1:0] i_bytes,
  input  logic [2:0]        i_funct3,
  output logic [DATA_W-1:0] o_data
);

  logic w_sign;

  always_comb begin
    w_sign = 1'b0;
    o_data = ZERO32;
    case (i_funct3[1:0])
      SIZE_BYTE: begin
        w_sign = ~i_funct3[2] & i_bytes[7];
        o_data = {{24{w_sign}}, i_bytes[7:0]};
      end
      SIZE_HALF: begin
        w_sign = ~i_funct3[2] & i_bytes[15];
        o_data = {{16{w_sign}}, i_bytes[15:0]};
      end
      default: o_data = i_bytes;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: splits loads/stores into byte requests and registers
// the write-back triple. Define MEM_FWD_EN to add the combinational forward port.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 valid_in,
  input  logic [1:0]           memOp_in,
  input  logic [2:0]           funct3_in,
  input  logic [ADDR_W-1:0]    addr_in,
  input  logic [DATA_W-1:0]    storeData_in,
  input  logic [DATA_W-1:0]    aluData_in,
  input  logic                 wE_in,
  input  logic [REG_IDX_W-1:0] wIdx_in,
  output logic                 stall_out,
  output logic                 memReq_out,
  output logic                 memWe_out,
  output logic [ADDR_W-1:0]    memAddr_out,
  output logic [7:0]           memWdata_out,
  input  logic                 memAck_in,
  input  logic [7:0]           memRdata_in,
`ifdef MEM_FWD_EN
  output logic                 fwdE_out,
  output logic [REG_IDX_W-1:0] fwdIdx_out,
  output logic [DATA_W-1:0]    fwdData_out,
`endif
  output logic                 wbE_out,
  output logic [REG_IDX_W-1:0] wbIdx_out,
  output logic [DATA_W-1:0]    wbData_out,
  output logic                 dbgState_out
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACCESS = 1'b1;

  logic [0:0]           r_state;
  logic                 r_store;
  logic [2:0]           r_f3;
  logic [ADDR_W-1:0]    r_base;
  logic [DATA_W-1:0]    r_sdata;
  logic [REG_IDX_W-1:0] r_wIdx;
  logic [1:0]           r_cnt;
  logic [DATA_W-1:0]    r_buf;
  logic                 r_wbE;
  logic [REG_IDX_W-1:0] r_wbIdx;
  logic [DATA_W-1:0]    r_wbData;

  logic                 w_access;
  logic                 w_is_mem;
  logic                 w_ack;
  logic                 w_last;
  logic [DATA_W-1:0]    w_buf_next;
  logic [DATA_W-1:0]    w_ext;

  assign w_access = (r_state == S_ACCESS);
  assign w_is_mem = (memOp_in == MEMOP_LOAD) || (memOp_in == MEMOP_STORE);
  assign w_ack    = w_access && memAck_in;
  assign w_last   = (r_cnt == last_byte(r_f3[1:0]));

  // The acked byte is merged before extension so the final ack can write back directly.
  always_comb begin
    w_buf_next = r_buf;
    w_buf_next[8*r_cnt +: 8] = memRdata_in;
  end

  mem_load_ext u_ext (
    .i_bytes  (w_buf_next),
    .i_funct3 (r_f3),
    .o_data   (w_ext)
  );

  assign stall_out    = w_access;
  assign memReq_out   = w_access;
  assign memWe_out    = w_access && r_store;
  assign memAddr_out  = w_access ? (r_base + {{(ADDR_W-2){1'b0}}, r_cnt}) : '0;
  assign memWdata_out = (w_access && r_store) ? r_sdata[8*r_cnt +: 8] : 8'd0;
  assign wbE_out      = r_wbE;
  assign wbIdx_out    = r_wbIdx;
  assign wbData_out   = r_wbData;
  assign dbgState_out = r_state;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state  <= S_IDLE;
      r_store  <= 1'b0;
      r_f3     <= '0;
      r_base   <= '0;
      r_sdata  <= ZERO32;
      r_wIdx   <= '0;
      r_cnt    <= '0;
      r_buf    <= ZERO32;
      r_wbE    <= DISABLE;
      r_wbIdx  <= '0;
      r_wbData <= ZERO32;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (valid_in && w_is_mem) begin
            r_state  <= S_ACCESS;
            r_store  <= (memOp_in == MEMOP_STORE);
            r_f3     <= funct3_in;
            r_base   <= addr_in;
            r_sdata  <= storeData_in;
            r_wIdx   <= wIdx_in;
            r_cnt    <= '0;
            r_buf    <= ZERO32;
            r_wbE    <= DISABLE;
            r_wbIdx  <= '0;
            r_wbData <= ZERO32;
          end else if (valid_in) begin
            r_wbE    <= wE_in && (wIdx_in != '0);
            r_wbIdx  <= wIdx_in;
            r_wbData <= aluData_in;
          end else begin
            r_wbE    <= DISABLE;
            r_wbIdx  <= '0;
            r_wbData <= ZERO32;
          end
        end
        default: begin
          if (w_ack) begin
            if (!r_store) r_buf <= w_buf_next;
            if (w_last) begin
              r_state <= S_IDLE;
              if (!r_store) begin
                r_wbE    <= (r_wIdx != '0);
                r_wbIdx  <= r_wIdx;
                r_wbData <= w_ext;
              end else begin
                r_wbE    <= DISABLE;
                r_wbIdx  <= '0;
                r_wbData <= ZERO32;
              end
            end else begin
              r_cnt <= r_cnt + 2'd1;
            end
          end
        end
      endcase
    end
  end

`ifdef MEM_FWD_EN
  always_comb begin
    fwdE_out    = DISABLE;
    fwdIdx_out  = '0;
    fwdData_out = ZERO32;
    if (!rst_in) begin
      if (!w_access && valid_in && !w_is_mem) begin
        fwdE_out    = wE_in && (wIdx_in != '0);
        fwdIdx_out  = wIdx_in;
        fwdData_out = aluData_in;
      end else if (w_ack && w_last && !r_store) begin
        fwdE_out    = (r_wIdx != '0);
        fwdIdx_out  = r_wIdx;
        fwdData_out = w_ext;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage; build with MEM_FWD_EN to also check forwarding.
module tb_mem_stage;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        valid_in = 1'b0;
  logic [1:0]  memOp_in = '0;
  logic [2:0]  funct3_in = '0;
  logic [31:0] addr_in = '0;
  logic [31:0] storeData_in = '0;
  logic [31:0] aluData_in = '0;
  logic        wE_in = 1'b0;
  logic [4:0]  wIdx_in = '0;
  logic        stall_out;
  logic        memReq_out;
  logic        memWe_out;
  logic [31:0] memAddr_out;
  logic [7:0]  memWdata_out;
  logic        memAck_in = 1'b0;
  logic [7:0]  memRdata_in = '0;
  logic        wbE_out;
  logic [4:0]  wbIdx_out;
  logic [31:0] wbData_out;
  logic        dbgState_out;
`ifdef MEM_FWD_EN
  logic        fwdE_out;
  logic [4:0]  fwdIdx_out;
  logic [31:0] fwdData_out;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk_in = ~clk_in;

  mem_stage #(.ADDR_W(32)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .valid_in     (valid_in),
    .memOp_in     (memOp_in),
    .funct3_in    (funct3_in),
    .addr_in      (addr_in),
    .storeData_in (storeData_in),
    .aluData_in   (aluData_in),
    .wE_in        (wE_in),
    .wIdx_in      (wIdx_in),
    .stall_out    (stall_out),
    .memReq_out   (memReq_out),
    .memWe_out    (memWe_out),
    .memAddr_out  (memAddr_out),
    .memWdata_out (memWdata_out),
    .memAck_in    (memAck_in),
    .memRdata_in  (memRdata_in),
`ifdef MEM_FWD_EN
    .fwdE_out     (fwdE_out),
    .fwdIdx_out   (fwdIdx_out),
    .fwdData_out  (fwdData_out),
`endif
    .wbE_out      (wbE_out),
    .wbIdx_out    (wbIdx_out),
    .wbData_out   (wbData_out),
    .dbgState_out (dbgState_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk_wb(input string tag, input logic e, input logic [4:0] idx, input logic [31:0] d);
    chk({tag, "_wbE"}, {31'd0, wbE_out}, {31'd0, e});
    chk({tag, "_wbIdx"}, {27'd0, wbIdx_out}, {27'd0, idx});
    chk({tag, "_wbData"}, wbData_out, d);
  endtask

  task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd, input logic [31:0] alu, input logic we,
                       input logic [4:0] idx);
    valid_in = 1'b1; memOp_in = op; funct3_in = f3; addr_in = a;
    storeData_in = sd; aluData_in = alu; wE_in = we; wIdx_in = idx;
  endtask

  // Answers n byte requests, holding each for `waits` cycles before the ack.
  task automatic serve(input int n, input int waits, input logic [31:0] base, input logic we,
                       input logic [31:0] wd, input logic [31:0] rd, input logic fwd_exp);
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      a = base + i;
      for (int w = 0; w < waits; w++) begin
        chk("req_hold", {31'd0, memReq_out}, 32'd1);
        chk("addr_hold", memAddr_out, a);
        chk("stall_hold", {31'd0, stall_out}, 32'd1);
        step();
      end
      memAck_in = 1'b1;
      memRdata_in = rd[8*i +: 8];
      #1;
      chk("req", {31'd0, memReq_out}, 32'd1);
      chk("addr", memAddr_out, a);
      chk("we", {31'd0, memWe_out}, {31'd0, we});
      chk("stall", {31'd0, stall_out}, 32'd1);
      if (we) chk("wdata", {24'd0, memWdata_out}, {24'd0, wd[8*i +: 8]});
`ifdef MEM_FWD_EN
      chk("fwdE_ack", {31'd0, fwdE_out}, {31'd0, fwd_exp && (i == n - 1)});
`else
      if (fwd_exp) vectors += 0;
`endif
      step();
      memAck_in = 1'b0;
      memRdata_in = 8'd0;
    end
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_req", {31'd0, memReq_out}, 32'd0);
    chk("rst_stall", {31'd0, stall_out}, 32'd0);
    chk("rst_state", {31'd0, dbgState_out}, 32'd0);
    chk_wb("rst", 1'b0, 5'd0, 32'd0);
    step();
    step();
    rst_in = 1'b0;

    // ALU op passes through in one cycle
    issue(2'd0, 3'd0, 32'h0, 32'h0, 32'h1234, 1'b1, 5'd5);
`ifdef MEM_FWD_EN
    #1;
    chk("alu_fwdE", {31'd0, fwdE_out}, 32'd1);
    chk("alu_fwdData", fwdData_out, 32'h1234);
`endif
    step();
    valid_in = 1'b0;
    chk_wb("alu", 1'b1, 5'd5, 32'h1234);
    chk("alu_stall", {31'd0, stall_out}, 32'd0);
    step();
    chk_wb("bubble", 1'b0, 5'd0, 32'd0);

    // wIdx=0 forces wbE low; memOp=3 behaves as a non-memory op
    issue(2'd0, 3'd0, 32'h0, 32'h0, 32'hCAFE0001, 1'b1, 5'd0);
    step();
    chk_wb("alu_x0", 1'b0, 5'd0, 32'hCAFE0001);
    issue(2'd3, 3'd2, 32'h300, 32'h0, 32'h00000077, 1'b1, 5'd12);
    step();
    valid_in = 1'b0;
    chk_wb("op3", 1'b1, 5'd12, 32'h77);
    chk("op3_req", {31'd0, memReq_out}, 32'd0);

    // Ack while idle is ignored
    memAck_in = 1'b1;
    step();
    memAck_in = 1'b0;
    chk("idle_ack_state", {31'd0, dbgState_out}, 32'd0);
    chk("idle_ack_req", {31'd0, memReq_out}, 32'd0);

    // LB at 0x100, byte 0x80 -> sign-extended
    issue(2'd1, 3'b000, 32'h100, 32'h0, 32'h0, 1'b1, 5'd7);
    step();
    valid_in = 1'b0;
    chk("lb_acc_wbE", {31'd0, wbE_out}, 32'd0);
    serve(1, 0, 32'h100, 1'b0, 32'h0, 32'h80, 1'b1);
    chk_wb("lb", 1'b1, 5'd7, 32'hFFFFFF80);
    chk("lb_req_done", {31'd0, memReq_out}, 32'd0);

    // LBU
    issue(2'd1, 3'b100, 32'h100, 32'h0, 32'h0, 1'b1, 5'd7);
    step();
    valid_in = 1'b0;
    serve(1, 0, 32'h100, 1'b0, 32'h0, 32'h80, 1'b1);
    chk_wb("lbu", 1'b1, 5'd7, 32'h00000080);

    // SW 0xDEADBEEF at 0x203: four writes, stall exactly 4 cycles
    issue(2'd2, 3'b010, 32'h203, 32'hDEADBEEF, 32'h0, 1'b1, 5'd9);
    step();
    valid_in = 1'b0;
    serve(4, 0, 32'h203, 1'b1, 32'hDEADBEEF, 32'h0, 1'b0);
    chk("sw_stall_end", {31'd0, stall_out}, 32'd0);
    chk_wb("sw", 1'b0, 5'd0, 32'd0);

    // LW across the address wrap with two wait cycles per byte
    issue(2'd1, 3'b010, 32'hFFFFFFFE, 32'h0, 32'h0, 1'b1, 5'd3);
    step();
    valid_in = 1'b0;
    serve(4, 2, 32'hFFFFFFFE, 1'b0, 32'h0, 32'h11223344, 1'b1);
    chk_wb("lw_wrap", 1'b1, 5'd3, 32'h11223344);

    // LH signed and unsigned
    issue(2'd1, 3'b001, 32'h10, 32'h0, 32'h0, 1'b1, 5'd4);
    step();
    valid_in = 1'b0;
    serve(2, 1, 32'h10, 1'b0, 32'h0, 32'h00008001, 1'b1);
    chk_wb("lh", 1'b1, 5'd4, 32'hFFFF8001);
    issue(2'd1, 3'b101, 32'h10, 32'h0, 32'h0, 1'b1, 5'd4);
    step();
    valid_in = 1'b0;
    serve(2, 0, 32'h10, 1'b0, 32'h0, 32'h00008001, 1'b1);
    chk_wb("lhu", 1'b1, 5'd4, 32'h00008001);

    // Reset after the second ack of an LW
    issue(2'd1, 3'b010, 32'h40, 32'h0, 32'h0, 1'b1, 5'd6);
    step();
    valid_in = 1'b0;
    serve(2, 0, 32'h40, 1'b0, 32'h0, 32'hA5A5A5A5, 1'b0);
    chk("mid_req", {31'd0, memReq_out}, 32'd1);
    chk("mid_addr", memAddr_out, 32'h42);
    rst_in = 1'b1;
    #1;
    chk("rst_mid_req", {31'd0, memReq_out}, 32'd0);
    chk("rst_mid_stall", {31'd0, stall_out}, 32'd0);
    chk("rst_mid_addr", memAddr_out, 32'd0);
    chk_wb("rst_mid", 1'b0, 5'd0, 32'd0);
    step();
    rst_in = 1'b0;
    issue(2'd0, 3'd0, 32'h0, 32'h0, 32'h5555AAAA, 1'b1, 5'd31);
    step();
    valid_in = 1'b0;
    chk_wb("post_rst_alu", 1'b1, 5'd31, 32'h5555AAAA);
    chk("post_rst_state", {31'd0, dbgState_out}, 32'd0);

    // Load to x0 completes without write-back or forward
    issue(2'd1, 3'b000, 32'h500, 32'h0, 32'h0, 1'b1, 5'd0);
    step();
    valid_in = 1'b0;
    serve(1, 1, 32'h500, 1'b0, 32'h0, 32'h7F, 1'b0);
    chk("ld_x0_wbE", {31'd0, wbE_out}, 32'd0);
    chk("ld_x0_state", {31'd0, dbgState_out}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
